// File: rtl/ste_audio_pkg.sv
// ste_audio_pkg: shared LMC1992 command codes, level limits and the 2 dB gain table.
package ste_audio_pkg;
    localparam logic [1:0] LMC_ADDR   = 2'b10;
    localparam logic [2:0] CMD_MIX    = 3'b000;
    localparam logic [2:0] CMD_BASS   = 3'b001;
    localparam logic [2:0] CMD_TREBLE = 3'b010;
    localparam logic [2:0] CMD_MASTER = 3'b011;
    localparam logic [2:0] CMD_RIGHT  = 3'b100;
    localparam logic [2:0] CMD_LEFT   = 3'b101;
    localparam logic [5:0] MAX_MASTER = 6'd40;
    localparam logic [4:0] MAX_LR     = 5'd20;
    localparam logic [3:0] MAX_TONE   = 4'd12;
    // 0, -2 and -4 dB in Q8; whole 6 dB steps are handled by the shifter
    function automatic logic [8:0] gain_g(input logic [1:0] i);
        return i == 2'd0 ? 9'd256 : i == 2'd1 ? 9'd203 : 9'd161;
    endfunction
endpackage

// File: rtl/lmc_gain_stage.sv
// lmc_gain_stage: per-channel fine gain multiply followed by coarse arithmetic shift.
module lmc_gain_stage
    import ste_audio_pkg::*;
(
    input  logic               clk32,
    input  logic               reset,
    input  logic               valid,
    input  logic signed [7:0]  m,
    input  logic        [1:0]  gidx,
    input  logic        [4:0]  sh,
    output logic signed [15:0] out,
    output logic               out_valid
);
    logic signed [17:0] prod;
    logic signed [15:0] p;
    logic        [4:0]  sh2;
    logic               v2;
    assign prod = m * $signed({1'b0, gain_g(gidx)});
    always_ff @(posedge clk32) begin
        if (reset) begin
            p         <= '0;
            sh2       <= '0;
            v2        <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            v2        <= valid;
            out_valid <= v2;
            if (valid) begin
                p   <= prod[15:0];
                sh2 <= sh;
            end
            if (v2) out <= p >>> sh2;
        end
    end
endmodule

// File: rtl/ste_lmc1992.sv
// ste_lmc1992: LMC1992 microwire decoder and volume/mix audio path for the STE DMA sound.
module ste_lmc1992
    import ste_audio_pkg::*;
#(
    parameter logic [5:0] MASTER_RST = 6'd40,
    parameter logic [4:0] LR_RST     = 5'd20,
    parameter logic [3:0] TONE_RST   = 4'd6,
    parameter logic [1:0] MIX_RST    = 2'd1
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        mw_strobe,
    input  logic        mw_clk,
    input  logic        mw_data,
    input  logic        mw_done,
    input  logic        sample_en,
    input  logic [7:0]  audio_left,
    input  logic [7:0]  audio_right,
    input  logic [7:0]  ym_audio,
    output logic [15:0] out_left,
    output logic [15:0] out_right,
    output logic        out_valid,
    output logic [3:0]  bass,
    output logic [3:0]  treble
);
    logic [10:0] sr, sr_n;
    logic [3:0]  cnt, cnt_n;
    logic        shift, hit;
    logic [2:0]  cmd;
    logic [5:0]  d, master, master_d, step_l, step_r;
    logic [4:0]  left_vol, right_vol, lr_d, sh_l, sh_r;
    logic [3:0]  tone_d;
    logic [1:0]  mix, gidx_l, gidx_r;
    logic [7:0]  m_l, m_r;
    logic        v1, vl, vr;

    function automatic logic [7:0] mix_s(input logic [7:0] raw, input logic [7:0] ym, input logic [1:0] mx);
        logic [7:0] s, y;
        logic [8:0] sum;
        s   = {~raw[7], raw[6:0]};
        y   = {~ym[7], ym[6:0]};
        sum = {s[7], s} + {y[7], y};
        return mx[1] ? s : sum[8:1];
    endfunction

    // the strobe's bit lands before a same-cycle mw_done looks at the frame
    assign shift    = mw_strobe && mw_clk;
    assign sr_n     = shift ? {sr[9:0], mw_data} : sr;
    assign cnt_n    = shift ? (cnt == 4'd15 ? cnt : cnt + 4'd1) : cnt;
    assign hit      = mw_done && cnt_n >= 4'd11 && sr_n[10:9] == LMC_ADDR;
    assign cmd      = sr_n[8:6];
    assign d        = sr_n[5:0];
    assign master_d = d > MAX_MASTER ? MAX_MASTER : d;
    assign lr_d     = d[4:0] > MAX_LR ? MAX_LR : d[4:0];
    assign tone_d   = d[3:0] > MAX_TONE ? MAX_TONE : d[3:0];
    assign step_l   = (MAX_MASTER - master) + {1'b0, MAX_LR - left_vol};
    assign step_r   = (MAX_MASTER - master) + {1'b0, MAX_LR - right_vol};

    always_ff @(posedge clk32) begin
        if (reset) begin
            sr        <= '0;
            cnt       <= '0;
            master    <= MASTER_RST;
            left_vol  <= LR_RST;
            right_vol <= LR_RST;
            bass      <= TONE_RST;
            treble    <= TONE_RST;
            mix       <= MIX_RST;
            v1        <= 1'b0;
            m_l       <= '0;
            m_r       <= '0;
            gidx_l    <= '0;
            gidx_r    <= '0;
            sh_l      <= '0;
            sh_r      <= '0;
        end else begin
            sr  <= sr_n;
            cnt <= mw_done ? 4'd0 : cnt_n;
            if (hit) begin
                case (cmd)
                    CMD_MASTER: master    <= master_d;
                    CMD_LEFT:   left_vol  <= lr_d;
                    CMD_RIGHT:  right_vol <= lr_d;
                    CMD_TREBLE: treble    <= tone_d;
                    CMD_BASS:   bass      <= tone_d;
                    CMD_MIX:    mix       <= d[1:0];
                    default: ;
                endcase
            end
            v1 <= sample_en;
            if (sample_en) begin
                m_l    <= mix_s(audio_left, ym_audio, mix);
                m_r    <= mix_s(audio_right, ym_audio, mix);
                gidx_l <= 2'(step_l % 6'd3);
                gidx_r <= 2'(step_r % 6'd3);
                sh_l   <= 5'(step_l / 6'd3);
                sh_r   <= 5'(step_r / 6'd3);
            end
        end
    end

    lmc_gain_stage u_left (
        .clk32(clk32), .reset(reset), .valid(v1), .m(m_l), .gidx(gidx_l), .sh(sh_l),
        .out(out_left), .out_valid(vl)
    );

    lmc_gain_stage u_right (
        .clk32(clk32), .reset(reset), .valid(v1), .m(m_r), .gidx(gidx_r), .sh(sh_r),
        .out(out_right), .out_valid(vr)
    );

    assign out_valid = vl && vr;
endmodule

// File: tb/tb_ste_lmc1992.sv
// tb_ste_lmc1992: directed microwire frames and samples with hand-computed outputs.
module tb_ste_lmc1992;
    logic        clk32 = 1'b0;
    logic        reset = 1'b1;
    logic        mw_strobe = 1'b0, mw_clk = 1'b0, mw_data = 1'b0, mw_done = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  audio_left = 8'h80, audio_right = 8'h80, ym_audio = 8'h80;
    logic [15:0] out_left, out_right;
    logic        out_valid;
    logic [3:0]  bass, treble;
    int          n_cmp = 0, n_bad = 0;

    ste_lmc1992 dut (
        .clk32(clk32), .reset(reset), .mw_strobe(mw_strobe), .mw_clk(mw_clk),
        .mw_data(mw_data), .mw_done(mw_done), .sample_en(sample_en),
        .audio_left(audio_left), .audio_right(audio_right), .ym_audio(ym_audio),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .bass(bass), .treble(treble)
    );

    always #5 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wbit(input logic b, input logic valid, input logic done);
        mw_strobe = 1'b1;
        mw_clk    = valid;
        mw_data   = b;
        mw_done   = done;
        @(negedge clk32);
        mw_strobe = 1'b0;
        mw_clk    = 1'b0;
        mw_data   = 1'b0;
        mw_done   = 1'b0;
    endtask

    // mode 0: no done, 1: done with the last bit, 2: done one cycle after
    task automatic send(input logic [15:0] bits, input int n, input int mode);
        for (int i = n - 1; i >= 0; i--) wbit(bits[i], 1'b1, mode == 1 && i == 0);
        if (mode == 2) begin
            mw_done = 1'b1;
            @(negedge clk32);
            mw_done = 1'b0;
        end
    endtask

    task automatic frame(input logic [2:0] cmd, input logic [5:0] d);
        send({5'b0, 2'b10, cmd, d}, 11, 1);
    endtask

    task automatic sample(input logic [7:0] l, input logic [7:0] r, input logic [7:0] y,
                          input logic [15:0] el, input logic [15:0] er);
        audio_left  = l;
        audio_right = r;
        ym_audio    = y;
        sample_en   = 1'b1;
        @(negedge clk32);
        sample_en = 1'b0;
        @(posedge clk32);
        #1 chk("latency", 16'(out_valid), 16'd0);
        @(posedge clk32);
        #1 chk("valid", 16'(out_valid), 16'd1);
        chk("out_left", out_left, el);
        chk("out_right", out_right, er);
        @(negedge clk32);
    endtask

    initial begin
        // T1: reset state, then mix DMA only at 0 dB; right clamp 63 -> 20
        @(negedge clk32);
        @(negedge clk32);
        chk("rst_left", out_left, 16'h0000);
        chk("rst_right", out_right, 16'h0000);
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_bass", 16'(bass), 16'd6);
        chk("rst_treble", 16'(treble), 16'd6);
        reset = 1'b0;
        @(negedge clk32);
        frame(3'b000, 6'd2);
        frame(3'b100, 6'd63);
        sample(8'hC0, 8'h40, 8'h80, 16'h4000, 16'hC000);
        // T2: master 37 (-6 dB), then clamp back to 40
        frame(3'b011, 6'd37);
        sample(8'hC0, 8'h40, 8'h80, 16'h2000, 16'hE000);
        frame(3'b011, 6'd63);
        sample(8'hC0, 8'h40, 8'h80, 16'h4000, 16'hC000);
        // T3: master 0, left 20 -> step 40
        frame(3'b011, 6'd0);
        frame(3'b101, 6'd20);
        sample(8'hC0, 8'h80, 8'h80, 16'h0001, 16'h0000);
        sample(8'h00, 8'h40, 8'h80, 16'hFFFC, 16'hFFFE);
        // T4: short frame, wrong address, ignored command, 12-bit frame with a masked slot
        frame(3'b011, 6'd40);
        frame(3'b110, 6'd1);
        send(16'b0_011_000000, 10, 2);
        sample(8'hC0, 8'h40, 8'h80, 16'h4000, 16'hC000);
        send(16'b11_011_000000, 11, 2);
        sample(8'hC0, 8'h40, 8'h80, 16'h4000, 16'hC000);
        send(16'b110101, 6, 0);
        wbit(1'b1, 1'b0, 1'b0);
        send(16'b001010, 6, 2);
        sample(8'hC0, 8'h40, 8'h80, 16'h0658, 16'hC000);
        // T5: DMA+YM mix, tone decode and clamp
        frame(3'b101, 6'd20);
        frame(3'b000, 6'd1);
        sample(8'hC0, 8'h80, 8'h40, 16'h0000, 16'hE000);
        sample(8'hFF, 8'h80, 8'hFF, 16'h7F00, 16'h3F00);
        frame(3'b010, 6'b001111);
        frame(3'b001, 6'd3);
        chk("treble", 16'(treble), 16'd12);
        chk("bass", 16'(bass), 16'd3);
        // T6: reset mid-frame with a sample in flight
        frame(3'b011, 6'd37);
        sample(8'hC0, 8'h80, 8'h80, 16'h1000, 16'h0000);
        send(16'b10011, 5, 0);
        audio_left = 8'hC0;
        sample_en  = 1'b1;
        @(negedge clk32);
        sample_en = 1'b0;
        reset     = 1'b1;
        @(negedge clk32);
        reset = 1'b0;
        chk("r2_left", out_left, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk32);
            chk("r2_valid", 16'(out_valid), 16'd0);
        end
        chk("r2_bass", 16'(bass), 16'd6);
        chk("r2_treble", 16'(treble), 16'd6);
        sample(8'hC0, 8'h80, 8'h80, 16'h2000, 16'h0000);
        frame(3'b011, 6'd37);
        sample(8'hC0, 8'h80, 8'h80, 16'h1000, 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
